// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch unit feeding 1/2/3-word instructions to the decoder
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_req/mem_addr             registered single-outstanding read request (even byte address)
//   mem_ack/mem_rdata            read completion and data
//   redirect/redirect_pc         flush queue and restart fetch at redirect_pc (bit 0 ignored)
//   inst_valid/inst_ready        head-instruction handshake with the decoder
//   inst/inst_len/inst_pc        head instruction words, length code (01/10/11), byte address

module fetch_unit #(
    parameter int SIZE   = 16,
    parameter int ADDR   = 16,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [SIZE-1:0]   mem_rdata,
    input  logic              redirect,
    input  logic [ADDR-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [3*SIZE-1:0] inst,
    output logic [1:0]        inst_len,
    output logic [ADDR-1:0]   inst_pc
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic [ADDR-1:0]   mem_addr_q;
    logic [ADDR-1:0]   fetch_pc_q;
    logic [ADDR-1:0]   inst_pc_q;
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [SIZE-1:0]   q_mem [QDEPTH];

    logic [SIZE-1:0]   w0, w1, w2;
    logic [1:0]        head_len;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic [1:0]        pop_len;
    logic [CW-1:0]     count_d;
    logic [ADDR-1:0]   fetch_pc_inc;
    logic [ADDR-1:0]   redirect_tgt;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= QDEPTH) s = s - QDEPTH;
        return PW'(s);
    endfunction

    always_comb begin
        w0 = q_mem[rd_ptr_q];
        w1 = q_mem[ptr_add(rd_ptr_q, 2'd1)];
        w2 = q_mem[ptr_add(rd_ptr_q, 2'd2)];

        // Top two bits of the head word give the instruction length; 00 and 01 are both 1 word.
        case (w0[SIZE-1:SIZE-2])
            2'b11:   head_len = 2'b11;
            2'b10:   head_len = 2'b10;
            default: head_len = 2'b01;
        endcase

        head_valid   = (count_q >= CW'(head_len));

        // Redirect wins over both queue operations in the same cycle.
        pop          = head_valid && inst_ready && !redirect;
        pop_len      = pop ? head_len : 2'b00;
        push         = (state_q == S_REQ) && mem_ack && !redirect;
        count_d      = count_q - CW'(pop_len) + CW'(push);

        fetch_pc_inc = fetch_pc_q + ADDR'(2);
        redirect_tgt = redirect_pc & ~ADDR'(1);
    end

    // Queue storage needs no reset: count_q alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr_q] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_pc_q <= '0;
            inst_pc_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            if (redirect) begin
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                inst_pc_q  <= redirect_tgt;
                fetch_pc_q <= redirect_tgt;
                case (state_q)
                    S_REQ, S_DISCARD: begin
                        if (mem_ack) begin
                            // The in-flight request completes now; its data is dropped.
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= redirect_tgt;
                        end else begin
                            // Request must stay stable until acked; its data is discarded later.
                            state_q    <= S_DISCARD;
                        end
                    end
                    default: begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= redirect_tgt;
                    end
                endcase
            end else begin
                count_q   <= count_d;
                rd_ptr_q  <= ptr_add(rd_ptr_q, pop_len);
                inst_pc_q <= inst_pc_q + ADDR'({pop_len, 1'b0});
                if (push) wr_ptr_q <= ptr_add(wr_ptr_q, 2'd1);

                case (state_q)
                    S_IDLE: begin
                        // No push can occur in IDLE, so count_d is the post-pop count.
                        if (count_d < CW'(QDEPTH)) begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= fetch_pc_q;
                        end
                    end
                    S_REQ: begin
                        if (mem_ack) begin
                            fetch_pc_q <= fetch_pc_inc;
                            if (count_d < CW'(QDEPTH)) begin
                                mem_addr_q <= fetch_pc_inc;
                            end else begin
                                state_q   <= S_IDLE;
                                mem_req_q <= 1'b0;
                            end
                        end
                    end
                    S_DISCARD: begin
                        if (mem_ack) begin
                            state_q    <= S_REQ;
                            mem_addr_q <= fetch_pc_q;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = head_valid;
    assign inst_len   = head_valid ? head_len : 2'b00;
    assign inst       = head_valid ? {(head_len == 2'b11) ? w2 : {SIZE{1'b0}},
                                      head_len[1]         ? w1 : {SIZE{1'b0}},
                                      w0}
                                   : {3*SIZE{1'b0}};

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [47:0] inst;
    logic [1:0]  inst_len;
    logic [15:0] inst_pc;

    logic [15:0] tbl [16];
    int          n_cmp;
    int          n_err;

    fetch_unit #(.SIZE(16), .ADDR(16), .QDEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_len    (inst_len),
        .inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory data follows the address held for the coming edge; sample 1 time unit after it.
    task automatic tick();
        mem_rdata = tbl[mem_addr[4:1]];
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        for (int i = 0; i < 16; i++) tbl[i] = 16'(i + 1);

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_mem_req",    64'(mem_req),    64'd0);
        chk("rst_mem_addr",   64'(mem_addr),   64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst_len",   64'(inst_len),   64'd0);
        chk("rst_inst",       64'(inst),       64'd0);
        chk("rst_inst_pc",    64'(inst_pc),    64'd0);

        // 1-word stream, zero-wait memory
        @(negedge clk);
        rst_n      = 1'b1;
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("s1_req",   64'(mem_req),    64'd1);
        chk("s1_addr0", 64'(mem_addr),   64'h0);
        chk("s1_nval",  64'(inst_valid), 64'd0);
        tick();
        chk("s1_val",   64'(inst_valid), 64'd1);
        chk("s1_inst0", 64'(inst),       64'h0001);
        chk("s1_len0",  64'(inst_len),   64'h1);
        chk("s1_pc0",   64'(inst_pc),    64'h0);
        chk("s1_addr2", 64'(mem_addr),   64'h2);
        tick();
        chk("s1_inst1", 64'(inst),       64'h0002);
        chk("s1_pc1",   64'(inst_pc),    64'h2);
        chk("s1_addr4", 64'(mem_addr),   64'h4);

        // Mixed lengths
        tbl[0] = 16'h8011; tbl[1] = 16'h2222; tbl[2] = 16'hC033;
        tbl[3] = 16'h4444; tbl[4] = 16'h5555; tbl[5] = 16'h0666;
        tbl[6] = 16'h0000;
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("mx_flush", 64'(inst_valid), 64'd0);
        chk("mx_addr0", 64'(mem_addr),   64'h0);
        tick();
        chk("mx_partial", 64'(inst_valid), 64'd0);
        tick();
        chk("mx_inst2", 64'(inst),     64'h0000_2222_8011);
        chk("mx_len2",  64'(inst_len), 64'h2);
        chk("mx_pc2",   64'(inst_pc),  64'h0);
        tick();
        chk("mx_wait3", 64'(inst_valid), 64'd0);
        chk("mx_pc4",   64'(inst_pc),    64'h4);
        tick();
        chk("mx_wait3b", 64'(inst_valid), 64'd0);
        tick();
        chk("mx_inst3", 64'(inst),     64'h5555_4444_C033);
        chk("mx_len3",  64'(inst_len), 64'h3);
        chk("mx_pc3",   64'(inst_pc),  64'h4);
        tick();
        chk("mx_inst1", 64'(inst),     64'h0666);
        chk("mx_len1",  64'(inst_len), 64'h1);
        chk("mx_pc10",  64'(inst_pc),  64'hA);

        // Backpressure: queue fills, requests stop, one pop re-arms
        for (int i = 0; i < 16; i++) tbl[i] = 16'h0100 + 16'(i);
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        inst_ready  = 1'b0;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        chk("bp_req3", 64'(mem_req), 64'd1);
        tick();
        chk("bp_full_req", 64'(mem_req), 64'd0);
        chk("bp_head",     64'(inst),    64'h0100);
        tick();
        chk("bp_hold_req", 64'(mem_req), 64'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("bp_rearm_req",  64'(mem_req),  64'd1);
        chk("bp_rearm_addr", 64'(mem_addr), 64'h8);
        chk("bp_next_inst",  64'(inst),     64'h0101);
        chk("bp_next_pc",    64'(inst_pc),  64'h2);

        // Redirect during wait state
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        inst_ready  = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        tick();
        mem_ack = 1'b0;
        chk("rw_addr6", 64'(mem_addr), 64'h6);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0101;
        tick();
        redirect = 1'b0;
        chk("rw_hold_req",  64'(mem_req),    64'd1);
        chk("rw_hold_addr", 64'(mem_addr),   64'h6);
        chk("rw_flush",     64'(inst_valid), 64'd0);
        chk("rw_inst_pc",   64'(inst_pc),    64'h0100);
        tick();
        chk("rw_hold_addr2", 64'(mem_addr), 64'h6);
        mem_ack = 1'b1;
        tick();
        chk("rw_new_addr", 64'(mem_addr),   64'h0100);
        chk("rw_dropped",  64'(inst_valid), 64'd0);
        tick();
        chk("rw_new_inst", 64'(inst),    64'h0100);
        chk("rw_new_pc",   64'(inst_pc), 64'h0100);

        // Address wrap
        tbl[15] = 16'h8AAA; tbl[0] = 16'h0BBB; tbl[1] = 16'h0CCC;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        chk("wr_addr_fffe", 64'(mem_addr),   64'hFFFE);
        chk("wr_flush",     64'(inst_valid), 64'd0);
        tick();
        chk("wr_addr_0",    64'(mem_addr),   64'h0000);
        chk("wr_partial",   64'(inst_valid), 64'd0);
        tick();
        chk("wr_inst",      64'(inst),     64'h0000_0BBB_8AAA);
        chk("wr_len",       64'(inst_len), 64'h2);
        chk("wr_pc_fffe",   64'(inst_pc),  64'hFFFE);
        tick();
        chk("wr_pc_2",      64'(inst_pc),  64'h0002);
        chk("wr_inst_next", 64'(inst),     64'h0CCC);

        // Asynchronous reset mid-request
        chk("ar_pre_req", 64'(mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req",   64'(mem_req),    64'd0);
        chk("ar_valid", 64'(inst_valid), 64'd0);
        chk("ar_addr",  64'(mem_addr),   64'h0);
        chk("ar_pc",    64'(inst_pc),    64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_restart_req",  64'(mem_req),  64'd1);
        chk("ar_restart_addr", 64'(mem_addr), 64'h0);
        tick();
        chk("ar_restart_inst", 64'(inst),    64'h0BBB);
        chk("ar_restart_pc",   64'(inst_pc), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction prefetch unit; reads 16-bit instruction words from memory and hands complete 1/2/3-word instructions to the decoder. It sits in front of the decoder and feeds `program_counter`. `inst_len` uses the same 2-bit encoding as the PC `inc` input: 01 = +2, 10 = +4, 11 = +6. It keeps its own fetch address, buffers words in a small queue, and supports redirect (branch) with flush.

## Interface
- `SIZE`, 16, instruction word width in bits
- `ADDR`, 16, byte-address width
- `QDEPTH`, 4, queue depth in words; minimum 3
- `clk`  in  1  system clock; all state updates on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `mem_req`  out  1  read request, registered
- `mem_addr`  out  ADDR  byte address of the requested word; always even
- `mem_ack`  in  1  memory completes the request this cycle
- `mem_rdata`  in  SIZE  read data, valid when `mem_ack`=1
- `redirect`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  ADDR  new fetch address; bit 0 ignored (treated as 0)
- `inst_valid`  out  1  complete instruction present at the head of the queue
- `inst_ready`  in  1  decoder accepts the instruction
- `inst`  out  3*SIZE  word 0 in [SIZE-1:0], word 1 next, word 2 in the top slot; unused slots are 0
- `inst_len`  out  2  01/10/11 = 1/2/3 words; 00 when `inst_valid`=0
- `inst_pc`  out  ADDR  byte address of the head instruction

## Operation
- **Length decode** uses the head word bits [SIZE-1:SIZE-2]:
  - 00 or 01: 1 word
  - 10: 2 words
  - 11: 3 words
- `inst_valid` = `count` >= decoded length of the head word.
- **Queue:** circular buffer of QDEPTH words with `count` 0..QDEPTH.
  - Push and pop in the same cycle are both applied.
  - A pop removes `inst_len` words when `inst_valid` && `inst_ready`.
  - `inst_pc` advances by 2*len, mod 2^ADDR.
- **Fetch FSM:**
  - IDLE: if `count` after this cycle's pop is < QDEPTH, go to REQ and raise `mem_req` at `fetch_pc`.
  - REQ: hold `mem_req`/`mem_addr` stable until `mem_ack`. On ack:
    - push `mem_rdata`
    - `fetch_pc` += 2, wrapping mod 2^ADDR
    - stay in REQ (back-to-back request at the new address) if space remains after this cycle's push/pop; otherwise go to IDLE.
  - DISCARD: keep `mem_req` at the old address until `mem_ack`; drop the data and do not push. Then go to REQ at `fetch_pc`.
- Only one request is ever outstanding.
- **Redirect** has priority over push and pop in the same cycle:
  - `count` goes to 0 and `inst_valid` drops next cycle.
  - `fetch_pc` and `inst_pc` take `redirect_pc` with bit 0 cleared.
  - If the FSM is in REQ and there is no `mem_ack` this cycle, go to DISCARD.
  - If `mem_ack` occurs in the same cycle, that data is dropped; go to REQ at the new address.
  - From IDLE, go to REQ.
  - A redirect while in DISCARD updates the target address and stays in DISCARD.
- **Reset** (async, any time, including mid-request):
  - state IDLE, `mem_req`=0, `mem_addr`=0, `fetch_pc`=0, `inst_pc`=0, `count`=0
  - `inst_valid`=0, `inst_len`=00, `inst`=0
  - Queue contents are don't-care.
- A partial instruction at the head (`count` < len) waits; it is never presented.
- If QDEPTH words are buffered, no request is issued until a pop frees space.

## Timing
- All outputs are driven from registers or from queue state. There is no combinational path from `mem_ack`, `inst_ready` or `redirect` to any output.
- First request: `mem_req`=1 on the first posedge after `rst_n` deasserts.
- Word latency:
  - data acked at edge N is in the queue after edge N.
  - A 1-word instruction shows `inst_valid`=1 in cycle N+1.
- Throughput: with zero-wait memory (`mem_ack` tied high), one word per cycle is sustained.
- Redirect latency:
  - Redirect sampled at edge N.
  - `mem_req` at the new address is high after edge N, or after the discard ack if a request was pending.
  - The earliest `inst_valid` from the new stream is one cycle after its first ack.

## Test plan
- **Reset, then 1-word stream.** Memory returns 0x0001, 0x0002, ... with immediate ack and `inst_ready`=1. Required: `mem_addr` 0, 2, 4...; `inst_valid` from cycle 2; `inst`=0x0001 `inst_len`=01 `inst_pc`=0, then 0x0002 at `inst_pc`=2.
- **Mixed lengths.** Memory words 0x8011, 0x2222, 0xC033, 0x4444, 0x5555, 0x0666. Required:
  - `inst`=0x2222_8011 with `inst_len`=10 at `inst_pc` 0
  - then 0x5555_4444_C033 with len 11 at 4
  - then 0x0666 with len 01 at 10
- **Backpressure.** `inst_ready`=0 with 1-word instructions. Required: after 4 words `mem_req` stays 0. One pop re-arms `mem_req` next cycle at `mem_addr`=8.
- **Redirect during wait state.**
  - Setup: `mem_ack` held 0 at `mem_addr`=6; assert `redirect` with `redirect_pc`=0x0101.
  - Required: `mem_req` stays at 6 until ack; that data is dropped; next request is at 0x0100; `inst_pc`=0x0100.
- **Wrap.** Redirect to 0xFFFE with ADDR=16. Required: requests at 0xFFFE then 0x0000. A 2-word instruction at 0xFFFE is presented with `inst_pc`=0xFFFE; the next `inst_pc` is 0x0002.
- **Async reset mid-request.** Assert `rst_n`=0 between clock edges while `mem_req`=1. Required: `mem_req`, `inst_valid` and `count` are 0 immediately, and fetch restarts at address 0.
